// File: rtl/fir_filter_core.sv
// fir_filter_core: direct-form N-tap FIR on a signed M-bit sample stream.
// One sample per clock, no handshake; y is registered and reflects the
// sample captured on the same edge.
// Optional: define FIR_SATURATE_EN to clamp the scaled accumulator to the
// M-bit signed range; otherwise the low M bits are taken (two's-complement wrap).
module fir_filter_core #(
  parameter int                 N      = 8,
  parameter int                 M      = 8,
  parameter logic [N*M-1:0]     COEFFS = {N{{{(M-1){1'b0}}, 1'b1}}},
  parameter int                 SHIFT  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [M-1:0]  x,
  output logic signed [M-1:0]  y
);

  localparam int AW = 2*M + $clog2(N);

  // Only N-1 history registers are stored: the oldest delay stage would be
  // shifted in but never multiplied, so it has no effect on y.
  logic signed [M-1:0]    d     [N-1];
  logic signed [M-1:0]    taps  [N];
  logic signed [2*M-1:0]  prods [N];
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   shifted;
  logic signed [M-1:0]    y_next;

  // Tap vector: current input followed by the pre-shift history.
  always_comb begin
    taps[0] = x;
    for (int k = 1; k < N; k++) begin
      taps[k] = d[k-1];
    end
  end

  // Signed MxM products summed into a sign-extended accumulator that cannot overflow.
  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++) begin
      prods[k] = taps[k] * $signed(COEFFS[k*M +: M]);
      acc      = acc + AW'(prods[k]);
    end
  end

  // Arithmetic shift floors toward negative infinity.
  always_comb begin
    shifted = acc >>> SHIFT;
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-M+1){1'b0}}, {(M-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-M+1){1'b1}}, {(M-1){1'b0}}};

  // Clamp the scaled sum into the representable output range.
  always_comb begin
    y_next = shifted[M-1:0];
    if (shifted > Y_MAX) begin
      y_next = Y_MAX[M-1:0];
    end else if (shifted < Y_MIN) begin
      y_next = Y_MIN[M-1:0];
    end
  end
`else
  logic unused_hi;

  // Wrap: keep the low M bits; the discarded upper bits are intentionally dropped.
  always_comb begin
    y_next    = shifted[M-1:0];
    unused_hi = ^shifted[AW-1:M];
  end
`endif

  // Delay line and output register; reset clears all history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N-1; k++) begin
        d[k] <= '0;
      end
      y <= '0;
    end else begin
      d[0] <= x;
      for (int k = 1; k < N-1; k++) begin
        d[k] <= d[k-1];
      end
      y <= y_next;
    end
  end

endmodule

// File: tb/tb_fir_filter_core.sv
// Testbench for fir_filter_core: a table of single-edge vectors on the
// default moving-average build, plus hand-written impulse and overflow
// sequences on two alternately-parameterised instances.
module tb_fir_filter_core;

  localparam int N = 8;
  localparam int M = 8;

  localparam logic [N*M-1:0] C_RAMP = {8'sd8, 8'sd7, 8'sd6, 8'sd5,
                                       8'sd4, 8'sd3, 8'sd2, 8'sd1};
  localparam logic [N*M-1:0] C_BIG  = {N{8'sd127}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a, rst_b, rst_c;
  logic signed [M-1:0] x_a, x_b, x_c;
  logic signed [M-1:0] y_a, y_b, y_c;

  fir_filter_core #(.N(N), .M(M), .SHIFT(3)) u_avg (
    .clk(clk), .reset(rst_a), .x(x_a), .y(y_a));

  fir_filter_core #(.N(N), .M(M), .COEFFS(C_RAMP), .SHIFT(0)) u_ramp (
    .clk(clk), .reset(rst_b), .x(x_b), .y(y_b));

  fir_filter_core #(.N(N), .M(M), .COEFFS(C_BIG), .SHIFT(0)) u_big (
    .clk(clk), .reset(rst_c), .x(x_c), .y(y_c));

  typedef struct {
    logic                rst;
    logic signed [M-1:0] x;
    logic signed [M-1:0] y;
  } vec_t;

  vec_t tv[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input int xv, input int yv);
    vec_t v;
    v.rst = r;
    v.x   = M'(xv);
    v.y   = M'(yv);
    tv.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic signed [M-1:0] got,
                       input logic signed [M-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: y=%0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic signed [M-1:0] OVF1 =
`ifdef FIR_SATURATE_EN
    8'sd127;
`else
    8'sd1;
`endif
  localparam logic signed [M-1:0] OVF2 =
`ifdef FIR_SATURATE_EN
    8'sd127;
`else
    8'sd2;
`endif

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    x_a = '0; x_b = '0; x_c = '0;

    // Reset ignores x; release with x=8 gives 8>>>3 = 1.
    add(0, 100, 0);
    add(0, 100, 0);
    add(1, 8, 1);
    add(0, 0, 0);
    // Positive step ramps by 10 per edge then holds.
    for (int k = 1; k <= 8; k++) add(1, 80, 10*k);
    add(1, 80, 80);
    add(1, 80, 80);
    // Mid-stream reset clears history.
    add(0, 80, 0);
    add(1, 8, 1);
    add(0, 0, 0);
    // Negative step.
    for (int k = 1; k <= 8; k++) add(1, -128, -16*k);
    add(1, -128, -128);
    // -1 replacing -128 one tap at a time; floor keeps results odd-negative.
    add(1, -1, -113);
    add(1, -1, -97);
    add(1, -1, -81);
    add(1, -1, -65);
    add(1, -1, -49);
    add(1, -1, -33);
    add(1, -1, -17);
    add(1, -1, -1);
    add(1, -1, -1);

    for (int i = 0; i < tv.size(); i++) begin
      rst_a = tv[i].rst;
      x_a   = tv[i].x;
      tick();
      check("avg", i, y_a, tv[i].y);
    end

    // Impulse through c_k = k+1, no shift.
    rst_b = 1'b0; x_b = 8'sd5;
    tick();
    check("ramp_rst", 0, y_b, 8'sd0);
    rst_b = 1'b1; x_b = 8'sd1;
    tick();
    check("ramp_imp", 0, y_b, 8'sd1);
    x_b = 8'sd0;
    for (int k = 1; k < N; k++) begin
      tick();
      check("ramp_imp", k, y_b, M'(k + 1));
    end
    tick();
    check("ramp_imp", N, y_b, 8'sd0);
    tick();
    check("ramp_imp", N+1, y_b, 8'sd0);

    // Overflow: 127*127 = 16129, then 32258.
    rst_c = 1'b0; x_c = 8'sd127;
    tick();
    check("ovf_rst", 0, y_c, 8'sd0);
    rst_c = 1'b1;
    tick();
    check("ovf", 0, y_c, OVF1);
    tick();
    check("ovf", 1, y_c, OVF2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_filter_core.md
Name: fir_filter_core

Overview:
- Direct-form N-tap FIR filter on a signed M-bit sample stream; accepts one sample every clock, no handshake.
- Sits in the signal-processing datapath between a sample source and downstream consumers.
- Coefficients and output scaling are elaboration-time parameters.
- Default configuration is an N-point moving average: all coefficients 1, output shifted right by log2(N).

Parameters:
- N, 8, number of taps (>=2).
- M, 8, bit width of input samples, coefficients and output.
- COEFFS, {N{M'sd1}}: packed N*M-bit vector of signed coefficients. Bits [k*M +: M] hold c_k; c_0 multiplies the newest sample.
- SHIFT, 3: arithmetic right shift applied to the accumulator before output (0..2M+clog2(N)-1).

Ports:
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous reset, active-low (0 = reset), sampled on the clk rising edge.
- x  input  M  signed input sample, captured every rising edge while not in reset.
- y  output  M  signed filtered output, registered.

Behaviour:
- Reset (reset==0 at a rising edge): all N delay-line registers <= 0 and y <= 0. x is ignored. No asynchronous effect.
- Normal edge (reset==1):
  - Delay line shifts: d[0] <= x; d[k] <= d[k-1] for k = 1..N-1.
  - Same edge: y <= scale(sum_{k=0..N-1} c_k * s_k), where s_0 = x (current input) and s_k = d[k-1] (pre-shift contents).
  - Latency: a sample's contribution appears on y at the same edge that captures it. y is valid one clock edge after x is driven.
- Arithmetic:
  - Products are signed M x M -> 2M bits.
  - Accumulator is signed, 2M+clog2(N) bits wide; it never overflows internally.
  - scale() = arithmetic right shift by SHIFT, rounding toward negative infinity, then reduction to M bits (see Optional Feature).
- Samples entering immediately after reset see zeros in the history (ramp-up transient).
- Reset asserted mid-stream: all history is discarded at that edge; no partial state is retained.
- No valid/ready signals: every non-reset edge is a sample.
- y holds its value only across reset; otherwise it updates every edge.

Optional Feature:
- Macro: FIR_SATURATE_EN.
- Defined: the shifted accumulator is clamped to [-2^(M-1), 2^(M-1)-1] before driving y.
- Undefined: y takes the low M bits of the shifted accumulator (two's-complement wrap). No clamp logic is generated.
- Both variants are identical when no overflow occurs, which includes the default moving-average configuration.

Test Plan:
- Reset: reset=0 for 2 edges with x=100 -> y=0. Release and drive x=8 -> y=1 at the next edge.
- Step, defaults: constant x=80 after reset -> y = 10,20,30,...,80 over 8 edges, then holds at 80.
- Negative step, defaults: constant x=-128 after reset -> y = -16,-32,...,-128, then holds at -128. Then constant x=-1 -> shifted sum stays at -1 due to floor, e.g. the first edge gives (-7*128-1)>>>3 = -113.
- Impulse, COEFFS c_k=k+1, SHIFT=0: x=1 for one edge then 0 -> y = 1,2,3,4,5,6,7,8, then 0.
- Overflow, COEFFS all 127, SHIFT=0, constant x=127, first edge (sum 16129):
  - With FIR_SATURATE_EN -> y=127.
  - Without -> y=1 (16129 mod 256).
- Mid-stream reset, defaults: after reaching steady y=80, one reset edge -> y=0. Then x=8 -> y=1, confirming history was cleared.
